// File: rtl/demux_contador_canais.sv
// Per-channel rising-edge counter placed after the 1-to-4 demux.
// Counts rising edges on each y line inside a WIN-cycle window opened by start,
// saturating per channel with a sticky overflow flag. Counts are read back one
// channel at a time through a registered read port.
module demux_contador_canais #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  y,
  input  logic             start,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [1:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [N_CH-1:0]  ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_t;

  localparam logic [15:0]      TimerLoad = 16'(WIN - 1);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  state_t           r_state, w_state_d;
  logic [N_CH-1:0]  r_y_q;
  logic [N_CH-1:0]  w_rise;
  logic [15:0]      r_timer, w_timer_d;
  logic [CNT_W-1:0] r_cnt [N_CH];
  logic [CNT_W-1:0] w_cnt_d [N_CH];
  logic [N_CH-1:0]  r_ovf, w_ovf_d;

  assign w_rise = y & ~r_y_q;

  // Next-state logic: clr dominates, then start (outside COUNT), then counting.
  always_comb begin
    w_state_d = r_state;
    w_timer_d = r_timer;
    w_cnt_d   = r_cnt;
    w_ovf_d   = r_ovf;
    if (clr) begin
      w_state_d = StIdle;
      w_timer_d = '0;
      w_ovf_d   = '0;
      for (int unsigned i = 0; i < N_CH; i++) w_cnt_d[i] = '0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            w_state_d = StCount;
            w_timer_d = TimerLoad;
            w_ovf_d   = '0;
            for (int unsigned i = 0; i < N_CH; i++) w_cnt_d[i] = '0;
          end
        end
        StCount: begin
          for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_rise[i]) begin
              if (r_cnt[i] == CntMax) w_ovf_d[i] = 1'b1;
              else                    w_cnt_d[i] = r_cnt[i] + 1'b1;
            end
          end
          // Edges on the last window cycle (timer==0) are still counted above.
          if (r_timer == 16'd0) w_state_d = StDone;
          else                  w_timer_d = r_timer - 16'd1;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // State, timer, counters, flags and edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_timer <= '0;
      r_ovf   <= '0;
      r_y_q   <= '0;
      for (int unsigned i = 0; i < N_CH; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_state_d;
      r_timer <= w_timer_d;
      r_ovf   <= w_ovf_d;
      r_y_q   <= y;
      for (int unsigned i = 0; i < N_CH; i++) r_cnt[i] <= w_cnt_d[i];
    end
  end

  // Read port samples the current (pre-update) count; rd_data holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= r_cnt[rd_sel];
    end
  end

  assign ovf  = r_ovf;
  assign busy = (r_state == StCount);
  assign done = (r_state == StDone);

endmodule
